// File: rtl/axi4lite_reg_slave.sv
// AXI4-Lite register bank: NUM_REGS 32-bit registers with byte strobes,
// independent write/read channel FSMs and configurable read wait states.
module axi4lite_reg_slave #(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 16,
    parameter int RD_WAIT  = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ADDR_W-1:0]        awaddr,
    input  logic                     awvalid,
    output logic                     awready,
    input  logic [DATA_W-1:0]        wdata,
    input  logic [3:0]               wstrb,
    input  logic                     wvalid,
    output logic                     wready,
    output logic [1:0]               bresp,
    output logic                     bvalid,
    input  logic                     bready,
    input  logic [ADDR_W-1:0]        araddr,
    input  logic                     arvalid,
    output logic                     arready,
    output logic [DATA_W-1:0]        rdata,
    output logic [1:0]               rresp,
    output logic                     rvalid,
    input  logic                     rready,
    output logic [NUM_REGS*32-1:0]   reg_q
);

    localparam int                IDX_W    = ADDR_W - 2;
    localparam logic [IDX_W:0]    NUM_L    = (IDX_W+1)'(NUM_REGS);
    localparam logic [3:0]        CNT_INIT = (RD_WAIT > 0) ? 4'(RD_WAIT - 1) : 4'd0;
    localparam logic [1:0]        RESP_OKAY   = 2'b00;
    localparam logic [1:0]        RESP_SLVERR = 2'b10;

    if (DATA_W != 32) begin : g_bad_data_w
        $error("axi4lite_reg_slave: DATA_W must be 32");
    end

    typedef enum logic {W_IDLE, W_RESP} wstate_t;
    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} rstate_t;

    // Byte-lane merge: lanes with strb set take the new data.
    function automatic logic [31:0] merge_strb(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        for (int k = 0; k < 4; k++) begin
            res[8*k +: 8] = strb[k] ? new_v[8*k +: 8] : old_v[8*k +: 8];
        end
        return res;
    endfunction

    // A word index addresses a real register only below NUM_REGS.
    function automatic logic in_range(input logic [IDX_W-1:0] idx);
        return ({1'b0, idx} < NUM_L);
    endfunction

    wstate_t            wstate_q;
    rstate_t            rstate_q;
    logic               aw_held_q, w_held_q;
    logic [IDX_W-1:0]   awidx_q;
    logic [31:0]        wdata_q;
    logic [3:0]         wstrb_q;
    logic               bvalid_q;
    logic [1:0]         bresp_q;
    logic [IDX_W-1:0]   ridx_q;
    logic [3:0]         rcnt_q;
    logic               rvalid_q;
    logic [1:0]         rresp_q;
    logic [31:0]        rdata_q;
    logic [31:0]        regs_q [NUM_REGS];
    logic [31:0]        regs_d [NUM_REGS];

    logic               aw_hs, w_hs, wr_commit, wr_ok;
    logic [IDX_W-1:0]   wr_idx;
    logic [31:0]        wr_data;
    logic [3:0]         wr_strb;
    logic [IDX_W-1:0]   rd_idx;
    logic [31:0]        rd_word;
    logic               rd_ok;
    logic               unused_addr_lsbs;

    assign unused_addr_lsbs = &{1'b0, awaddr[1:0], araddr[1:0]};

    // Ready signals decode straight from state so they read 1 under reset.
    assign awready = (wstate_q == W_IDLE) && !aw_held_q;
    assign wready  = (wstate_q == W_IDLE) && !w_held_q;
    assign arready = (rstate_q == R_IDLE);

    assign aw_hs     = awvalid && awready;
    assign w_hs      = wvalid && wready;
    assign wr_commit = (wstate_q == W_IDLE) && (aw_held_q || aw_hs) && (w_held_q || w_hs);
    assign wr_idx    = aw_hs ? awaddr[ADDR_W-1:2] : awidx_q;
    assign wr_data   = w_hs ? wdata : wdata_q;
    assign wr_strb   = w_hs ? wstrb : wstrb_q;
    assign wr_ok     = in_range(wr_idx);

    // RD_WAIT=0 loads data at the AR edge, so the index comes straight off araddr.
    assign rd_idx = (rstate_q == R_IDLE) ? araddr[ADDR_W-1:2] : ridx_q;
    assign rd_ok  = in_range(rd_idx);

    // Read mux over the register array; out-of-range reads return zero.
    always_comb begin
        rd_word = 32'd0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rd_idx == IDX_W'(i)) rd_word = regs_q[i];
        end
    end

    // Next register contents: only the committed, in-range word changes.
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_d[i] = regs_q[i];
            if (wr_commit && wr_ok && (wr_idx == IDX_W'(i))) begin
                regs_d[i] = merge_strb(regs_q[i], wr_data, wr_strb);
            end
        end
    end

    // Register array storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= 32'd0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
        end
    end

    // Latch AW address and W payload when each handshake completes on its own.
    always_ff @(posedge clk) begin
        if (aw_hs) awidx_q <= awaddr[ADDR_W-1:2];
        if (w_hs) begin
            wdata_q <= wdata;
            wstrb_q <= wstrb;
        end
    end

    // Write channel FSM: collect AW and W in any order, commit, hold B until accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wstate_q  <= W_IDLE;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
        end else begin
            case (wstate_q)
                W_IDLE: begin
                    if (aw_hs) aw_held_q <= 1'b1;
                    if (w_hs)  w_held_q  <= 1'b1;
                    if (wr_commit) begin
                        wstate_q <= W_RESP;
                        bvalid_q <= 1'b1;
                        bresp_q  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
                    end
                end
                W_RESP: begin
                    if (bready) begin
                        wstate_q  <= W_IDLE;
                        bvalid_q  <= 1'b0;
                        aw_held_q <= 1'b0;
                        w_held_q  <= 1'b0;
                    end
                end
            endcase
        end
    end

    // Read channel FSM: capture index, optionally wait RD_WAIT cycles, hold R until accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rstate_q <= R_IDLE;
            ridx_q   <= '0;
            rcnt_q   <= 4'd0;
            rvalid_q <= 1'b0;
            rresp_q  <= RESP_OKAY;
            rdata_q  <= 32'd0;
        end else begin
            case (rstate_q)
                R_IDLE: begin
                    if (arvalid) begin
                        ridx_q <= araddr[ADDR_W-1:2];
                        if (RD_WAIT > 0) begin
                            rstate_q <= R_WAIT;
                            rcnt_q   <= CNT_INIT;
                        end else begin
                            rstate_q <= R_DATA;
                            rvalid_q <= 1'b1;
                            rdata_q  <= rd_ok ? rd_word : 32'd0;
                            rresp_q  <= rd_ok ? RESP_OKAY : RESP_SLVERR;
                        end
                    end
                end
                R_WAIT: begin
                    if (rcnt_q == 4'd0) begin
                        rstate_q <= R_DATA;
                        rvalid_q <= 1'b1;
                        rdata_q  <= rd_ok ? rd_word : 32'd0;
                        rresp_q  <= rd_ok ? RESP_OKAY : RESP_SLVERR;
                    end else begin
                        rcnt_q <= rcnt_q - 4'd1;
                    end
                end
                R_DATA: begin
                    if (rready) begin
                        rstate_q <= R_IDLE;
                        rvalid_q <= 1'b0;
                    end
                end
                default: rstate_q <= R_IDLE;
            endcase
        end
    end

    assign bvalid = bvalid_q;
    assign bresp  = bresp_q;
    assign rvalid = rvalid_q;
    assign rresp  = rresp_q;
    assign rdata  = rdata_q;

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign reg_q[32*g +: 32] = regs_q[g];
    end

endmodule

// File: tb/tb_axi4lite_reg_slave.sv
// Directed bench for axi4lite_reg_slave with RD_WAIT=3 and 16 registers.
module tb_axi4lite_reg_slave;

    localparam int ADDR_W   = 8;
    localparam int NUM_REGS = 16;
    localparam int RDW      = 3;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [ADDR_W-1:0]      awaddr, araddr;
    logic                   awvalid, wvalid, bready, arvalid, rready;
    logic                   awready, wready, bvalid, arready, rvalid;
    logic [31:0]            wdata, rdata;
    logic [3:0]             wstrb;
    logic [1:0]             bresp, rresp;
    logic [NUM_REGS*32-1:0] reg_q;

    int n_cmp = 0;
    int n_err = 0;

    axi4lite_reg_slave #(
        .ADDR_W(ADDR_W), .DATA_W(32), .NUM_REGS(NUM_REGS), .RD_WAIT(RDW)
    ) dut (
        .clk(clk), .rst(rst),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .reg_q(reg_q)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // AW and W presented in the same cycle; B accepted immediately.
    task automatic do_write(input logic [7:0] a, input logic [31:0] d,
                            input logic [3:0] s, input logic [1:0] exp_resp);
        awaddr = a; awvalid = 1'b1;
        wdata = d; wstrb = s; wvalid = 1'b1;
        bready = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        chk("wr_bvalid", bvalid, 1);
        chk("wr_bresp", bresp, exp_resp);
        tick();
        chk("wr_bdone", bvalid, 0);
    endtask

    // Read with rready high; checks latency, data and response.
    task automatic do_read(input logic [7:0] a, input logic [31:0] exp_d,
                           input logic [1:0] exp_resp);
        int n;
        araddr = a; arvalid = 1'b1; rready = 1'b1;
        tick();
        arvalid = 1'b0;
        n = 1;
        while (!rvalid && n < 20) begin
            tick();
            n++;
        end
        chk("rd_lat", n, RDW + 1);
        chk("rd_data", rdata, exp_d);
        chk("rd_resp", rresp, exp_resp);
        tick();
        chk("rd_done", rvalid, 0);
    endtask

    initial begin
        logic [NUM_REGS*32-1:0] snap;
        int stray;
        rst = 1'b1;
        awaddr = '0; awvalid = 0; wdata = '0; wstrb = '0; wvalid = 0; bready = 0;
        araddr = '0; arvalid = 0; rready = 0;
        tick();
        chk("rst_awready", awready, 1);
        chk("rst_wready", wready, 1);
        chk("rst_arready", arready, 1);
        chk("rst_bvalid", bvalid, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_rdata", rdata, 0);
        tick();
        rst = 1'b0;
        tick();

        for (int i = 0; i < NUM_REGS; i++) do_read(8'(4*i), 32'h0, 2'b00);
        chk("regq_zero", (reg_q == '0), 1);

        // Simultaneous AW+W
        do_write(8'h04, 32'hDEADBEEF, 4'b1111, 2'b00);
        chk("regq_w1", reg_q[32 +: 32], 32'hDEADBEEF);
        do_read(8'h04, 32'hDEADBEEF, 2'b00);

        // W leads AW by 3 cycles with partial strobes; B back-pressured.
        do_write(8'h08, 32'hDEADBEEF, 4'b1111, 2'b00);
        bready = 1'b0;
        wdata = 32'h11223344; wstrb = 4'b0101; wvalid = 1'b1;
        tick();
        wvalid = 1'b0;
        chk("w_first_wready", wready, 0);
        chk("w_first_awready", awready, 1);
        chk("w_first_bvalid", bvalid, 0);
        tick();
        tick();
        awaddr = 8'h08; awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        chk("late_aw_bvalid", bvalid, 1);
        chk("late_aw_bresp", bresp, 2'b00);
        chk("late_aw_reg2", reg_q[64 +: 32], 32'hDE22BE44);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("bhold_valid", bvalid, 1);
            chk("bhold_resp", bresp, 2'b00);
            chk("bhold_awready", awready, 0);
        end
        bready = 1'b1;
        tick();
        chk("bhold_done", bvalid, 0);
        chk("bhold_awready_back", awready, 1);
        do_read(8'h08, 32'hDE22BE44, 2'b00);

        // Out-of-range write and read; zero-strobe write
        snap = reg_q;
        do_write(8'h40, 32'hCAFEF00D, 4'b1111, 2'b10);
        chk("oor_regq_same", (reg_q == snap), 1);
        do_read(8'h40, 32'h0, 2'b10);
        do_write(8'h04, 32'h12345678, 4'b0000, 2'b00);
        chk("strb0_reg1", reg_q[32 +: 32], 32'hDEADBEEF);
        // Lane 3 only, address LSBs ignored
        do_write(8'h07, 32'hA5000000, 4'b1000, 2'b00);
        chk("lane3_reg1", reg_q[32 +: 32], 32'hA5ADBEEF);

        // Read wait states with rready back-pressure
        araddr = 8'h04; arvalid = 1'b1; rready = 1'b0;
        tick();
        arvalid = 1'b0;
        chk("rw_arready_wait", arready, 0);
        begin
            int n;
            n = 1;
            while (!rvalid && n < 20) begin
                chk("rw_arready_low", arready, 0);
                tick();
                n++;
            end
            chk("rw_lat", n, 4);
        end
        for (int i = 0; i < 5; i++) begin
            chk("rw_hold_valid", rvalid, 1);
            chk("rw_hold_data", rdata, 32'hA5ADBEEF);
            chk("rw_hold_arready", arready, 0);
            tick();
        end
        rready = 1'b1;
        tick();
        chk("rw_done_valid", rvalid, 0);
        chk("rw_done_arready", arready, 1);

        // Reset mid-transaction: B pending and read in R_WAIT
        awaddr = 8'h0C; awvalid = 1'b1; wdata = 32'h55AA55AA; wstrb = 4'hF; wvalid = 1'b1;
        bready = 1'b0;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        chk("mid_bvalid_pre", bvalid, 1);
        araddr = 8'h0C; arvalid = 1'b1; rready = 1'b1;
        tick();
        arvalid = 1'b0;
        chk("mid_arready_pre", arready, 0);
        rst = 1'b1;
        #1;
        chk("mid_bvalid_rst", bvalid, 0);
        chk("mid_rvalid_rst", rvalid, 0);
        chk("mid_regq_rst", (reg_q == '0), 1);
        chk("mid_arready_rst", arready, 1);
        chk("mid_awready_rst", awready, 1);
        tick();
        tick();
        rst = 1'b0;
        bready = 1'b1;
        stray = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bvalid || rvalid) stray++;
        end
        chk("mid_no_stray", stray, 0);
        do_read(8'h0C, 32'h0, 2'b00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
